// File: rtl/pokey_pkg.sv
// rtl/pokey_pkg.sv - shared types and constants for the POKEY pot scan engine
package pokey_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DUMP  = 2'd1,
    ST_COUNT = 2'd2
  } pot_state_e;

  localparam int DEF_MAX_COUNT  = 228;
  localparam int DEF_LINE_DIV   = 114;
  localparam int DEF_DUMP_TICKS = 2;

  // SKCTL fields consumed (already decoded) by the scanner
  localparam int SKCTL_FAST_BIT = 2;
  localparam int SKCTL_INIT_MSB = 1;
  localparam int SKCTL_INIT_LSB = 0;

endpackage

// File: rtl/pot_tick_gen.sv
// rtl/pot_tick_gen.sv - scan tick source: line divider or one tick per clk
module pot_tick_gen
  import pokey_pkg::*;
#(
  parameter int LINE_DIV = DEF_LINE_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic fast,
  output logic tick
);

  localparam logic [6:0] DIV_LAST = 7'(LINE_DIV - 1);

  logic [6:0] div;

  // Divider free-runs in both modes so a mode switch never restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (clr || div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 7'd1;
    end
  end

  assign tick = fast | (div == DIV_LAST);

endmodule

// File: rtl/pokey_pot_scanner.sv
// rtl/pokey_pot_scanner.sv - POTGO-triggered pot discharge and count/latch engine
module pokey_pot_scanner
  import pokey_pkg::*;
#(
  parameter int NUM_POTS   = 2,
  parameter int MAX_COUNT  = DEF_MAX_COUNT,
  parameter int LINE_DIV   = DEF_LINE_DIV,
  parameter int DUMP_TICKS = DEF_DUMP_TICKS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  potgo,
  input  logic                  skctl_fast,
  input  logic                  skctl_init,
  input  logic [NUM_POTS-1:0]   pot_in,
  output logic [NUM_POTS-1:0]   pot_dump,
  output logic [8*NUM_POTS-1:0] pot_value,
  output logic [NUM_POTS-1:0]   allpot,
  output logic                  scan_busy
);

  localparam logic [7:0] CNT_MAX   = 8'(MAX_COUNT);
  localparam logic [7:0] DUMP_LAST = 8'(DUMP_TICKS - 1);

  logic [NUM_POTS-1:0] pin_meta, pin_s;
  pot_state_e          state, state_nxt;
  logic [7:0]          cnt, cnt_nxt;
  logic [7:0]          dump_cnt, dump_nxt;
  logic [NUM_POTS-1:0] allpot_q, allpot_nxt;
  logic [NUM_POTS-1:0] latch;
  logic                tick, count_tick, terminal;

  // Synchronizer is deliberately left untouched by skctl_init
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_meta <= '0;
      pin_s    <= '0;
    end else begin
      pin_meta <= pot_in;
      pin_s    <= pin_meta;
    end
  end

  pot_tick_gen #(.LINE_DIV(LINE_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (potgo | skctl_init),
    .fast  (skctl_fast),
    .tick  (tick)
  );

  // A restart or init on the same cycle suppresses any latch
  assign count_tick = (state == ST_COUNT) && tick && !potgo && !skctl_init;
  assign terminal   = (cnt == CNT_MAX);

  for (genvar n = 0; n < NUM_POTS; n++) begin : g_pot
    logic [7:0] val_q;

    assign latch[n] = count_tick & allpot_q[n] & (pin_s[n] | terminal);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        val_q <= '0;
      end else if (skctl_init) begin
        val_q <= '0;
      end else if (latch[n]) begin
        val_q <= cnt;
      end
    end

    assign pot_value[8*n +: 8] = val_q;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dump_nxt   = dump_cnt;
    allpot_nxt = allpot_q;
    if (skctl_init) begin
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
      dump_nxt   = '0;
      allpot_nxt = '0;
    end else if (potgo) begin
      state_nxt  = ST_DUMP;
      cnt_nxt    = '0;
      dump_nxt   = '0;
      allpot_nxt = '1;
    end else begin
      case (state)
        ST_DUMP: begin
          if (tick) begin
            if (dump_cnt == DUMP_LAST) begin
              state_nxt = ST_COUNT;
              cnt_nxt   = '0;
            end else begin
              dump_nxt = dump_cnt + 8'd1;
            end
          end
        end
        ST_COUNT: begin
          if (allpot_q == '0) begin
            state_nxt = ST_IDLE;
          end else if (tick) begin
            if (terminal) begin
              allpot_nxt = '0;
              state_nxt  = ST_IDLE;
            end else begin
              allpot_nxt = allpot_q & ~latch;
              cnt_nxt    = cnt + 8'd1;
            end
          end
        end
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dump_cnt <= '0;
      allpot_q <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dump_cnt <= dump_nxt;
      allpot_q <= allpot_nxt;
    end
  end

  assign pot_dump  = {NUM_POTS{state != ST_COUNT}};
  assign scan_busy = (state != ST_IDLE);
  assign allpot    = allpot_q;

endmodule

// File: tb/tb_pokey_pot_scanner.sv
// tb/tb_pokey_pot_scanner.sv - directed self-checking bench for pokey_pot_scanner
module tb_pokey_pot_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        potgo = 1'b0;
  logic        skctl_fast = 1'b1;
  logic        skctl_init = 1'b0;
  logic [1:0]  pot_in = 2'b00;
  logic [1:0]  pot_dump;
  logic [15:0] pot_value;
  logic [1:0]  allpot;
  logic        scan_busy;

  int errors = 0;
  int checks = 0;

  pokey_pot_scanner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .potgo      (potgo),
    .skctl_fast (skctl_fast),
    .skctl_init (skctl_init),
    .pot_in     (pot_in),
    .pot_dump   (pot_dump),
    .pot_value  (pot_value),
    .allpot     (allpot),
    .scan_busy  (scan_busy)
  );

  always #5 clk = ~clk;

  // r0/r1: cycle offset (relative to COUNT entry) a pin rises; 0 = already high, 255 = never
  typedef struct {
    int         r0;
    int         r1;
    int         v0;
    int         v1;
    int         busy;
    logic [1:0] mid;
    bit         partial;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_potgo();
    potgo = 1'b1;
    step();
    potgo = 1'b0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_dump"}, 32'(pot_dump), 32'd3);
    chk({name, "_value"}, 32'(pot_value), 32'd0);
    chk({name, "_allpot"}, 32'(allpot), 32'd0);
    chk({name, "_busy"}, 32'(scan_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int prev0, prev1, busy, dump_fall, ap0_fall, ap1_fall;
    bit partial;

    vecs[0] = '{r0: 0,   r1: 255, v0: 0,   v1: 228, busy: 231, mid: 2'b10, partial: 1'b1};
    vecs[1] = '{r0: 57,  r1: 57,  v0: 57,  v1: 57,  busy: 61,  mid: 2'b00, partial: 1'b0};
    vecs[2] = '{r0: 10,  r1: 200, v0: 10,  v1: 200, busy: 204, mid: 2'b10, partial: 1'b1};
    vecs[3] = '{r0: 255, r1: 255, v0: 228, v1: 228, busy: 231, mid: 2'b11, partial: 1'b0};
    vecs[4] = '{r0: 150, r1: 3,   v0: 150, v1: 3,   busy: 154, mid: 2'b01, partial: 1'b1};
    vecs[5] = '{r0: 227, r1: 0,   v0: 227, v1: 0,   busy: 231, mid: 2'b01, partial: 1'b1};

    repeat (3) step();
    chk_reset_vals("in_reset");
    rst_n = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      step();
      if (i == 500) chk_reset_vals("idle_500");
    end
    chk_reset_vals("idle_1000");

    prev0 = 0;
    prev1 = 0;
    for (int v = 0; v < 6; v++) begin
      pot_in = 2'b00;
      repeat (4) step();
      if (vecs[v].r0 == 0) pot_in[0] = 1'b1;
      if (vecs[v].r1 == 0) pot_in[1] = 1'b1;
      repeat (3) step();
      pulse_potgo();
      busy = 0;
      partial = 1'b0;
      for (int i = 1; i < 300; i++) begin
        if (i == vecs[v].r0 + 1) pot_in[0] = 1'b1;
        if (i == vecs[v].r1 + 1) pot_in[1] = 1'b1;
        if (i == 1) begin
          chk($sformatf("v%0d_allpot_start", v), 32'(allpot), 32'd3);
          chk($sformatf("v%0d_hold0", v), 32'(pot_value[7:0]), 32'(prev0));
          chk($sformatf("v%0d_hold1", v), 32'(pot_value[15:8]), 32'(prev1));
        end
        if (i == 2) chk($sformatf("v%0d_dump_hi", v), 32'(pot_dump), 32'd3);
        if (i == 3) chk($sformatf("v%0d_dump_lo", v), 32'(pot_dump), 32'd0);
        if (i == 100) chk($sformatf("v%0d_allpot_mid", v), 32'(allpot), 32'(vecs[v].mid));
        if (allpot == 2'b01 || allpot == 2'b10) partial = 1'b1;
        if (!scan_busy) break;
        busy++;
        step();
      end
      chk($sformatf("v%0d_busy_len", v), 32'(busy), 32'(vecs[v].busy));
      chk($sformatf("v%0d_val0", v), 32'(pot_value[7:0]), 32'(vecs[v].v0));
      chk($sformatf("v%0d_val1", v), 32'(pot_value[15:8]), 32'(vecs[v].v1));
      chk($sformatf("v%0d_partial", v), 32'(partial), 32'(vecs[v].partial));
      chk($sformatf("v%0d_allpot_end", v), 32'(allpot), 32'd0);
      chk($sformatf("v%0d_dump_end", v), 32'(pot_dump), 32'd3);
      prev0 = vecs[v].v0;
      prev1 = vecs[v].v1;
    end

    // Slow mode: pot1 latches at cnt 0, pot0 at cnt 100
    skctl_fast = 1'b0;
    pot_in = 2'b10;
    repeat (4) step();
    pulse_potgo();
    dump_fall = 0;
    ap0_fall = 0;
    ap1_fall = 0;
    for (int i = 1; i < 13000; i++) begin
      if (i == 11700) pot_in[0] = 1'b1;
      if (dump_fall == 0 && pot_dump == 2'b00) dump_fall = i;
      if (ap1_fall == 0 && !allpot[1]) ap1_fall = i;
      if (ap0_fall == 0 && !allpot[0]) ap0_fall = i;
      if (!scan_busy) break;
      step();
    end
    chk("slow_count_entry", 32'(dump_fall), 32'd229);
    chk("slow_pot1_latch", 32'(ap1_fall), 32'd343);
    chk("slow_pot0_latch", 32'(ap0_fall), 32'd11743);
    chk("slow_val0", 32'(pot_value[7:0]), 32'd100);
    chk("slow_val1", 32'(pot_value[15:8]), 32'd0);
    chk("slow_idle", 32'(scan_busy), 32'd0);

    // Restart at cnt 80 after pot0 latched 40, then potgo on the terminal tick
    skctl_fast = 1'b1;
    pot_in = 2'b00;
    repeat (4) step();
    pulse_potgo();
    for (int i = 1; i < 83; i++) begin
      if (i == 41) pot_in[0] = 1'b1;
      step();
    end
    chk("rs_pre_val0", 32'(pot_value[7:0]), 32'd40);
    pulse_potgo();
    chk("rs_allpot", 32'(allpot), 32'd3);
    chk("rs_dump1", 32'(pot_dump), 32'd3);
    chk("rs_hold0", 32'(pot_value[7:0]), 32'd40);
    chk("rs_busy", 32'(scan_busy), 32'd1);
    step();
    chk("rs_dump2", 32'(pot_dump), 32'd3);
    step();
    chk("rs_count", 32'(pot_dump), 32'd0);
    step();
    chk("rs_cnt_restart", 32'(pot_value[7:0]), 32'd0);
    repeat (227) step();
    chk("term_pre_allpot", 32'(allpot), 32'd2);
    chk("term_pre_busy", 32'(scan_busy), 32'd1);
    pulse_potgo();
    chk("term_no_latch", 32'(pot_value[15:8]), 32'd0);
    chk("term_allpot", 32'(allpot), 32'd3);
    chk("term_dump", 32'(pot_dump), 32'd3);
    chk("term_busy", 32'(scan_busy), 32'd1);
    pot_in[1] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!scan_busy) break;
      step();
    end
    chk("term_scan_end", 32'(scan_busy), 32'd0);

    // skctl_init mid-COUNT, then potgo blocked while init held
    pot_in = 2'b00;
    repeat (4) step();
    pulse_potgo();
    for (int i = 1; i < 50; i++) begin
      if (i == 10) pot_in[0] = 1'b1;
      step();
    end
    chk("init_pre_val0", 32'(pot_value[7:0]), 32'd9);
    chk("init_pre_busy", 32'(scan_busy), 32'd1);
    skctl_init = 1'b1;
    step();
    chk_reset_vals("init_clear");
    pulse_potgo();
    chk("init_block_busy", 32'(scan_busy), 32'd0);
    chk("init_block_allpot", 32'(allpot), 32'd0);
    step();
    chk("init_block_busy2", 32'(scan_busy), 32'd0);
    skctl_init = 1'b0;
    step();
    chk("init_release_busy", 32'(scan_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pokey_pot_scanner.md
# pokey_pot_scanner

Paddle/potentiometer scan engine for the POKEY core. It sits between the header pot pins and the POKEY register file. On a POTGO strobe it discharges the pot capacitors, then counts scan ticks. When each pot input crosses threshold, it latches the current count into that pot's POT register and clears the pot's ALLPOT bit. The top-level integration drives the release/dump header pins from `pot_dump` and maps `pot_value`/`allpot` onto POT0/POT1/ALLPOT.

## Interface
- `NUM_POTS`, default 2: number of pot channels.
- `MAX_COUNT`, default 228: terminal scan count; 8-bit.
- `LINE_DIV`, default 114: clk cycles per scan tick in slow mode.
- `DUMP_TICKS`, default 2: ticks the capacitors are held discharged after POTGO.

Ports:
- `clk`: input, 1 bit. Machine clock. Single clock domain.
- `rst_n`: input, 1 bit. Reset, asynchronous, active-low.
- `potgo`: input, 1 bit. One-cycle strobe on a POTGO write.
- `skctl_fast`: input, 1 bit. SKCTL[2]. When 1, one tick per clk.
- `skctl_init`: input, 1 bit. High when SKCTL[1:0]==00. Synchronous clear.
- `pot_in`: input, NUM_POTS bits. Raw asynchronous comparator pins.
- `pot_dump`: output, NUM_POTS bits. 1 = discharge (release transistor on).
- `pot_value`: output, 8*NUM_POTS bits. Latched counts; pot n occupies [8n+7:8n].
- `allpot`: output, NUM_POTS bits. 1 = pot n still scanning.
- `scan_busy`: output, 1 bit. High in DUMP or COUNT.

## Operation
- `pot_in` passes through a 2-flop synchronizer. Only the synchronized value `pin_s` is used.
- Tick generator:
  - Slow mode: a 7-bit divider pulses `tick` every LINE_DIV cycles.
  - Fast mode: `tick` is 1 every cycle.
  - The divider clears on `potgo`.
- The FSM has three states: IDLE, DUMP, COUNT.
- IDLE:
  - `pot_dump` is all 1.
  - `allpot` is 0; `scan_busy` is 0.
  - `pot_value` holds the last scan result.
- `potgo` in any state: go to DUMP.
  - Clear the dump-tick counter and the scan counter `cnt`.
  - `allpot` becomes all 1.
  - `pot_value` is unchanged until each pot re-latches.
- DUMP:
  - `pot_dump` is all 1.
  - After DUMP_TICKS ticks, go to COUNT with `cnt`=0.
- COUNT:
  - `pot_dump` is all 0.
  - On each tick, every pot n with `allpot[n]`=1 and `pin_s[n]`=1 latches `pot_value[n]`=`cnt` and clears `allpot[n]`.
  - `cnt` then increments on that tick.
  - Several pots may latch on the same tick.
- Termination on a tick where `cnt`==MAX_COUNT:
  - Each pot still scanning latches MAX_COUNT.
  - `allpot` becomes all 0.
  - Go to IDLE.
- Early exit: if `allpot` becomes all 0 before MAX_COUNT, go to IDLE on the next cycle.
- `cnt` never exceeds MAX_COUNT. There is no wrap-around.
- `potgo` on the same cycle as a terminal or latch tick: `potgo` wins. No latch occurs; the scan restarts.
- `skctl_init`=1: same effect as reset, except the synchronizer is not cleared. Held-high `skctl_init` blocks `potgo`.
- Changing `skctl_fast` mid-scan takes effect on the next cycle. The divider is not reset.

## Timing
- Reset values:
  - FSM = IDLE.
  - `pot_dump` = all 1.
  - `pot_value` = 0.
  - `allpot` = 0.
  - `scan_busy` = 0.
  - `cnt` = 0; divider = 0.
- `potgo` at cycle t:
  - `allpot` = all 1 and `scan_busy` = 1 at t+1.
  - Fast mode: COUNT is entered at t+1+DUMP_TICKS.
- Pin to latch: an edge on `pot_in` is visible in `pin_s` 2 cycles later. It latches on the first tick after that.
- Outputs are registered. A latch is visible the cycle after its tick.
- Slow mode: `cnt` increments once per LINE_DIV cycles.
- A full fast-mode scan completes MAX_COUNT+1 ticks after COUNT entry.

## Structure
- `pokey_pkg` holds:
  - the FSM state enum (IDLE/DUMP/COUNT);
  - the default MAX_COUNT, LINE_DIV and DUMP_TICKS constants;
  - the SKCTL bit-index constants (FAST=2, INIT=1:0).
- One sub-module, `pot_tick_gen`: the divider plus fast-mode mux, producing `tick`.
- The synchronizer, counter and per-pot latch logic stay in the top module. The per-pot latch logic uses a generate loop over NUM_POTS.

## Test plan
- Reset: while `rst_n`=0, `pot_dump`=2'b11, `pot_value`=0, `allpot`=0, `scan_busy`=0. Release reset with no `potgo`: values stay put for 1000 cycles.
- Fast mode, `pot_in[0]` held 1, `pot_in[1]` held 0, `potgo` pulsed: `pot_value[0]`=0 and `pot_value[1]`=228. `allpot` = 11, then 10, then 00. `scan_busy` falls 229 ticks after COUNT entry.
- Slow mode, `pot_in[0]` rises so that `pin_s` is high just before the tick with `cnt`=100: `pot_value[0]`=100, and ticks are spaced 114 cycles apart.
- Both pins rise together at `cnt`=57 (fast mode): both values are 57, `allpot` goes 11 to 00 in one step, and FSM is IDLE the next cycle.
- Second `potgo` issued at `cnt`=80 with `pot_value[0]` previously 40: `allpot` returns to 11, `pot_dump` goes to 1 for DUMP_TICKS ticks, and `cnt` restarts at 0. `potgo` landing on the terminal tick restarts without latching 228.
- `skctl_init` pulsed mid-COUNT: all outputs return to reset values the next cycle. A `potgo` while `skctl_init`=1 is ignored.
